uart_cmd_master: RTL and testbench
==================================

# uart_cmd_master

Host-side initiator for the UART register-access protocol. Accepts a single register request (write or read burst), serialises it into the command/register/count byte frame and any write payload into the UART TX FIFO, then collects the read-response bytes from the UART RX FIFO. It sits between a local request source (test sequencer or host logic) and a UARTtransceiver instance whose link faces the on-chip register responder.

## Interface

- WATCHDOG_BITS, 12, width of the stall watchdog counter, which counts baud16 ticks.

- sysclk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- baud16  in  1  1-cycle tick at 16x baud, timebase for the watchdog
- req_valid  in  1  request present
- req_ready  out  1  =1 iff state IDLE (combinational)
- req_write  in  1  1 = write burst (cmd 0x01), 0 = read burst (cmd 0x02)
- req_reg  in  8  start register address
- req_count  in  8  burst length in bytes
- wr_data  in  8  write payload byte
- wr_data_valid  in  1  wr_data present
- wr_data_ack  out  1  payload byte consumed this cycle (combinational)
- tx_fifo_full  in  1  TX FIFO cannot accept a byte
- tx_fifo_write  out  1  push tx_fifo_data this cycle (combinational)
- tx_fifo_data  out  8  byte to TX FIFO, 0 when tx_fifo_write=0
- rx_dataAvailable  in  1  RX FIFO non-empty
- rx_data  in  8  RX FIFO head byte
- rx_read  out  1  pop RX FIFO this cycle (combinational)
- rd_data  out  8  received read byte (registered)
- rd_valid  out  1  rd_data valid, 1-cycle pulse
- busy  out  1  state != IDLE
- done  out  1  1-cycle pulse, transaction completed
- timeout  out  1  1-cycle pulse, transaction aborted by watchdog

## Operation

- States: IDLE, SEND_CMD, SEND_REG, SEND_CNT, SEND_DATA, WAIT_RX, DONE.
- IDLE: on req_valid, latch req_write/req_reg/req_count, clear idx (8 bit), go to SEND_CMD.
- SEND_CMD/SEND_REG/SEND_CNT: if !tx_fifo_full, tx_fifo_write=1 with data 0x01|0x02, req_reg, req_count respectively, and advance. Otherwise hold.
- After SEND_CNT:
  - write with count=0 goes to DONE.
  - write with count>0 goes to SEND_DATA.
  - read goes to WAIT_RX.
- SEND_DATA: when wr_data_valid && !tx_fifo_full, then tx_fifo_write=1, tx_fifo_data=wr_data, wr_data_ack=1, idx++. Go to DONE after byte idx==count-1.
- WAIT_RX: expected = (count==0) ? 1 : count, because the responder always returns at least one byte on a read.
  - When rx_dataAvailable, rx_read=1, and the next cycle gives rd_data=rx_data, rd_valid=1, idx++.
  - Go to DONE after byte idx==expected-1.
- DONE: done=1 for one cycle, then IDLE.
- RX bytes arriving outside WAIT_RX are not popped.
- Watchdog:
  - Counter is cleared on reset, on every state change, and on every tx_fifo_write or rx_read.
  - Otherwise it increments on baud16 while state != IDLE.
  - On a baud16 tick with the counter all ones: go to IDLE, pulse timeout, no done.
- Watchdog abort has priority over any progress in the same cycle.

## Timing

- Reset: state IDLE, idx 0, watchdog 0, rd_data 0, rd_valid 0, done 0, timeout 0.
- Combinational outputs follow state: req_ready=1 and busy=0 from the first cycle after reset.
- A request accepted at cycle T (req_valid&&req_ready) produces, with no backpressure:
  - cmd at T+1, reg at T+2, count at T+3.
  - Payload one byte per cycle from T+4.
- Write burst of N: done at T+4+N.
- Write with count 0: done at T+4.
- Read: pop at cycle P gives rd_valid at P+1. done is asserted in the cycle after the last rd_valid.
- Backpressure: tx_fifo_full or !wr_data_valid stalls with no write and no idx change. No byte is dropped or duplicated.
- req_valid while busy is ignored.
- Reset mid-transaction: IDLE next cycle, no further FIFO activity, no done/timeout pulse.

## Test plan

- Write req reg=0x10, count=3, payload A1,B2,C3, TX never full -> TX stream 01,10,03,A1,B2,C3 on consecutive cycles; done 1 cycle after C3; wr_data_ack x3.
- Read req reg=0x20, count=2, RX supplies 5A,6B -> TX 02,20,02; rx_read x2; rd_valid with 5A then 6B; done after 6B.
- Read count=0, RX supplies 77 -> TX 02,reg,00; exactly one rd_valid with 77; done.
- tx_fifo_full asserted for 5 cycles during SEND_REG -> reg byte written once after full drops; byte order unchanged; no extra writes.
- Read count=4 with only 1 RX byte, WATCHDOG_BITS=4 -> after 16 baud16 ticks without progress, timeout pulses, busy=0, no done, req_ready=1.
- Reset asserted during SEND_DATA of a count=5 write -> no TX writes after reset; next request starts cleanly with cmd byte.

Source files
------------

// File: rtl/uart_cmd_master.sv
// rtl/uart_cmd_master.sv - host-side UART register-access initiator
module uart_cmd_master #(
  parameter int WATCHDOG_BITS = 12
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       baud16,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_count,
  input  logic [7:0] wr_data,
  input  logic       wr_data_valid,
  output logic       wr_data_ack,
  input  logic       tx_fifo_full,
  output logic       tx_fifo_write,
  output logic [7:0] tx_fifo_data,
  input  logic       rx_dataAvailable,
  input  logic [7:0] rx_data,
  output logic       rx_read,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    SEND_REG  = 3'd2,
    SEND_CNT  = 3'd3,
    SEND_DATA = 3'd4,
    WAIT_RX   = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [WATCHDOG_BITS-1:0] WD_ONE = 1;

  state_t                   state;
  logic                     is_write;
  logic [7:0]               reg_q;
  logic [7:0]               cnt_q;
  logic [7:0]               idx;
  logic [WATCHDOG_BITS-1:0] wdog;

  logic       abort;
  logic       active;
  logic       rx_last;
  logic       wd_clear;
  logic [7:0] expected;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // A stalled transaction is abandoned on the tick that finds the counter saturated
  assign abort    = busy && baud16 && (&wdog);
  // Outputs that move bytes are suppressed while resetting or aborting
  assign active   = !reset && !abort;
  // A read always returns at least one byte, even for count 0
  assign expected = (cnt_q == 8'd0) ? 8'd1 : cnt_q;
  // All expected bytes popped; the extra cycle lets done follow the last rd_valid
  assign rx_last  = (state == WAIT_RX) && (idx == expected);
  // Any progress or state change restarts the stall watchdog
  assign wd_clear = tx_fifo_write || rx_read || !busy || (state == DONE) || rx_last;

  // FIFO handshakes decoded from the current state
  always_comb begin
    tx_fifo_write = 1'b0;
    tx_fifo_data  = 8'h00;
    wr_data_ack   = 1'b0;
    rx_read       = 1'b0;
    if (active) begin
      case (state)
        SEND_CMD: if (!tx_fifo_full) begin
          tx_fifo_write = 1'b1;
          tx_fifo_data  = is_write ? 8'h01 : 8'h02;
        end
        SEND_REG: if (!tx_fifo_full) begin
          tx_fifo_write = 1'b1;
          tx_fifo_data  = reg_q;
        end
        SEND_CNT: if (!tx_fifo_full) begin
          tx_fifo_write = 1'b1;
          tx_fifo_data  = cnt_q;
        end
        SEND_DATA: if (wr_data_valid && !tx_fifo_full) begin
          tx_fifo_write = 1'b1;
          tx_fifo_data  = wr_data;
          wr_data_ack   = 1'b1;
        end
        WAIT_RX: if (rx_dataAvailable && (idx != expected)) begin
          rx_read = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Transaction sequencer, watchdog and registered status pulses
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= IDLE;
      is_write <= 1'b0;
      reg_q    <= 8'h00;
      cnt_q    <= 8'h00;
      idx      <= 8'h00;
      wdog     <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      if (wd_clear) begin
        wdog <= '0;
      end else if (baud16) begin
        wdog <= wdog + WD_ONE;
      end
      if (abort) begin
        state   <= IDLE;
        timeout <= 1'b1;
        wdog    <= '0;
      end else begin
        if (rx_read) begin
          rd_data  <= rx_data;
          rd_valid <= 1'b1;
          idx      <= idx + 8'd1;
        end
        case (state)
          IDLE: if (req_valid) begin
            is_write <= req_write;
            reg_q    <= req_reg;
            cnt_q    <= req_count;
            idx      <= 8'h00;
            state    <= SEND_CMD;
          end
          SEND_CMD: if (tx_fifo_write) state <= SEND_REG;
          SEND_REG: if (tx_fifo_write) state <= SEND_CNT;
          SEND_CNT: if (tx_fifo_write) begin
            if (!is_write) begin
              state <= WAIT_RX;
            end else if (cnt_q == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SEND_DATA;
            end
          end
          SEND_DATA: if (tx_fifo_write) begin
            idx <= idx + 8'd1;
            if (idx == cnt_q - 8'd1) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          WAIT_RX: if (rx_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb/tb_uart_cmd_master.sv - table-driven bench for uart_cmd_master
module tb_uart_cmd_master;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       baud16 = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_count = 8'h00;
  logic [7:0] wr_data;
  logic       wr_data_valid = 1'b0;
  logic       wr_data_ack;
  logic       tx_fifo_full = 1'b0;
  logic       tx_fifo_write;
  logic [7:0] tx_fifo_data;
  logic       rx_dataAvailable = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_read;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic       timeout;

  always #5 sysclk = ~sysclk;

  uart_cmd_master #(.WATCHDOG_BITS(4)) dut (
    .sysclk(sysclk), .reset(reset), .baud16(baud16),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_reg(req_reg), .req_count(req_count),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ack(wr_data_ack),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_write(tx_fifo_write), .tx_fifo_data(tx_fifo_data),
    .rx_dataAvailable(rx_dataAvailable), .rx_data(rx_data), .rx_read(rx_read),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .timeout(timeout)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  rg;
    logic [7:0]  cnt;
    logic [63:0] pay;
    logic [63:0] rx;
    int          nrx;
    logic [63:0] etx;
    int          ntx;
    int          lat;
    int          nrd;
  } txn_t;

  txn_t tbl[5];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] tx_log[$];
  logic [7:0] rd_log[$];
  logic [7:0] rx_q[$];
  int done_cnt = 0, done_cyc = 0, to_cnt = 0, acc_cyc = 0;
  int ack_cnt = 0, pop_cnt = 0, tick_since = 0, to_ticks = 0;
  int full_wr = 0, data_nz = 0;
  bit pop_p = 1'b0, ack_p = 1'b0;
  logic [63:0] cur_payload = 64'h0;
  logic [2:0]  wr_idx = 3'd0;

  assign wr_data = cur_payload[63 - 8*wr_idx -: 8];

  function automatic logic [7:0] byte_at(input logic [63:0] v, input int i);
    return v[63 - 8*i -: 8];
  endfunction

  // Observe DUT outputs mid-cycle
  always @(negedge sysclk) begin
    pop_p = rx_read;
    ack_p = wr_data_ack;
    if (tx_fifo_write) tx_log.push_back(tx_fifo_data);
    else if (tx_fifo_data != 8'h00) data_nz++;
    if (tx_fifo_write && tx_fifo_full) full_wr++;
    if (rd_valid) rd_log.push_back(rd_data);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (timeout) begin to_cnt++; to_ticks = tick_since; end
    if (req_valid && req_ready) acc_cyc = cyc;
    if (wr_data_ack) ack_cnt++;
    if (rx_read) pop_cnt++;
    if (rx_read || tx_fifo_write) tick_since = 0;
    else if (baud16) tick_since++;
  end

  // RX FIFO model, payload source and baud16 timebase
  always @(posedge sysclk) begin
    cyc++;
    #1;
    if (pop_p && rx_q.size() > 0) rx_q.delete(0);
    if (ack_p) wr_idx = wr_idx + 3'd1;
    pop_p = 1'b0;
    ack_p = 1'b0;
    rx_dataAvailable = (rx_q.size() != 0);
    rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    baud16 = (cyc % 4 == 0);
  end

  task automatic tick();
    @(posedge sysclk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_end(input int d0, input int o0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != d0 || to_cnt != o0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_rx(input logic [63:0] v, input int n);
    rx_q.delete();
    for (int i = 0; i < n; i++) rx_q.push_back(byte_at(v, i));
    rx_dataAvailable = (rx_q.size() != 0);
    rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  task automatic issue(input bit wr, input logic [7:0] rg, input logic [7:0] cnt);
    req_write = wr;
    req_reg = rg;
    req_count = cnt;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input int k);
    txn_t t;
    int tb0, rb0, d0, o0, a0, p0;
    bit ok;
    t = tbl[k];
    tb0 = tx_log.size(); rb0 = rd_log.size();
    d0 = done_cnt; o0 = to_cnt; a0 = ack_cnt; p0 = pop_cnt;
    load_rx(t.rx, t.nrx);
    cur_payload = t.pay;
    wr_idx = 3'd0;
    wr_data_valid = 1'b1;
    issue(t.wr, t.rg, t.cnt);
    wait_end(d0, o0, 300, ok);
    check($sformatf("txn%0d_end", k), ok, 1);
    check($sformatf("txn%0d_ntx", k), tx_log.size() - tb0, t.ntx);
    for (int i = 0; i < t.ntx; i++)
      if (tb0 + i < tx_log.size())
        check($sformatf("txn%0d_tx%0d", k, i), tx_log[tb0 + i], byte_at(t.etx, i));
    check($sformatf("txn%0d_done_lat", k), done_cyc - acc_cyc, t.lat);
    check($sformatf("txn%0d_ndone", k), done_cnt - d0, 1);
    check($sformatf("txn%0d_timeout", k), to_cnt - o0, 0);
    check($sformatf("txn%0d_acks", k), ack_cnt - a0, t.wr ? t.cnt : 0);
    check($sformatf("txn%0d_pops", k), pop_cnt - p0, t.nrd);
    check($sformatf("txn%0d_nrd", k), rd_log.size() - rb0, t.nrd);
    for (int i = 0; i < t.nrd; i++)
      if (rb0 + i < rd_log.size())
        check($sformatf("txn%0d_rd%0d", k, i), rd_log[rb0 + i], byte_at(t.rx, i));
    check($sformatf("txn%0d_idle", k), busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int tb0, rb0, d0, o0, fw0, n;
    bit ok;

    tbl[0] = '{wr:1'b1, rg:8'h10, cnt:8'd3, pay:64'hA1B2C3_0000000000, rx:64'h0, nrx:0,
               etx:64'h011003A1B2C3_0000, ntx:6, lat:7, nrd:0};
    tbl[1] = '{wr:1'b0, rg:8'h20, cnt:8'd2, pay:64'h0, rx:64'h5A6B_000000000000, nrx:2,
               etx:64'h022002_0000000000, ntx:3, lat:7, nrd:2};
    tbl[2] = '{wr:1'b0, rg:8'h33, cnt:8'd0, pay:64'h0, rx:64'h7788_000000000000, nrx:2,
               etx:64'h023300_0000000000, ntx:3, lat:6, nrd:1};
    tbl[3] = '{wr:1'b1, rg:8'h44, cnt:8'd0, pay:64'h0, rx:64'h0, nrx:0,
               etx:64'h014400_0000000000, ntx:3, lat:4, nrd:0};
    tbl[4] = '{wr:1'b1, rg:8'hFF, cnt:8'd1, pay:64'h5C_00000000000000, rx:64'h0, nrx:0,
               etx:64'h01FF015C_00000000, ntx:4, lat:5, nrd:0};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge sysclk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_tx_write", tx_fifo_write, 0);
    check("rst_rx_read", rx_read, 0);
    tick();

    for (int k = 0; k < 5; k++) begin
      run_txn(k);
      repeat (2) tick();
    end

    // TX FIFO full for 5 cycles while the register byte is pending
    tb0 = tx_log.size(); d0 = done_cnt; o0 = to_cnt; fw0 = full_wr;
    load_rx(64'h0, 0);
    cur_payload = 64'h1122_000000000000;
    wr_idx = 3'd0;
    issue(1'b1, 8'h55, 8'd2);
    tick();
    tx_fifo_full = 1'b1;
    repeat (5) tick();
    tx_fifo_full = 1'b0;
    wait_end(d0, o0, 300, ok);
    check("bp_end", ok, 1);
    check("bp_ntx", tx_log.size() - tb0, 5);
    for (int i = 0; i < 5; i++)
      if (tb0 + i < tx_log.size())
        check($sformatf("bp_tx%0d", i), tx_log[tb0 + i], byte_at(64'h01550211_22000000, i));
    check("bp_done_lat", done_cyc - acc_cyc, 11);
    check("bp_write_while_full", full_wr - fw0, 0);
    repeat (2) tick();

    // Read of 4 with only one byte supplied: watchdog abort
    rb0 = rd_log.size(); d0 = done_cnt; o0 = to_cnt;
    load_rx(64'hC4_00000000000000, 1);
    issue(1'b0, 8'h66, 8'd4);
    wait_end(d0, o0, 300, ok);
    check("wd_end", ok, 1);
    check("wd_timeout", to_cnt - o0, 1);
    check("wd_no_done", done_cnt - d0, 0);
    check("wd_nrd", rd_log.size() - rb0, 1);
    if (rb0 < rd_log.size()) check("wd_rd0", rd_log[rb0], 8'hC4);
    check("wd_ticks", to_ticks, 16);
    check("wd_busy", busy, 0);
    check("wd_req_ready", req_ready, 1);
    repeat (2) tick();

    // Reset in the middle of a count=5 write payload
    tb0 = tx_log.size(); d0 = done_cnt; o0 = to_cnt;
    load_rx(64'h0, 0);
    cur_payload = 64'h1122334455_000000;
    wr_idx = 3'd0;
    issue(1'b1, 8'h77, 8'd5);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_log.size() >= tb0 + 5) begin ok = 1'b1; break; end
      tick();
    end
    check("mr_reach_data", ok, 1);
    n = tx_log.size();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("mr_no_tx", tx_log.size() - n, 0);
    check("mr_no_done", done_cnt - d0, 0);
    check("mr_no_timeout", to_cnt - o0, 0);
    check("mr_busy", busy, 0);
    run_txn(3);

    check("data_zero_when_idle", data_nz, 0);
    check("never_write_while_full", full_wr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
